// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle MIPS control FSM (cclk/rst; instr/zero/mem_ready/irq in; datapath mux selects, strobes, epc_write/cause, state out)
module mc_control_fsm #(
  parameter int ENABLE_EXC = 1,
  parameter int MEM_TIMEOUT = 15,
  parameter int STATE_W = 4
) (
  input  logic               cclk,
  input  logic               rst,
  input  logic [31:0]        instr,
  input  logic               zero,
  input  logic               mem_ready,
  input  logic               irq,
  output logic               pc_en,
  output logic [1:0]         pc_source,
  output logic               ior_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic [1:0]         mem_to_reg,
  output logic [1:0]         reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_op,
  output logic               epc_write,
  output logic [1:0]         cause,
  output logic [STATE_W-1:0] state
);
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC_M = 4'd2,
    MEM_L  = 4'd3,
    WB_L   = 4'd4,
    MEM_S  = 4'd5,
    EXEC_R = 4'd6,
    WB_R   = 4'd7,
    EXEC_B = 4'd8,
    EXEC_J = 4'd9,
    EXEC_I = 4'd10,
    EXC    = 4'd11
  } state_t;
  localparam int CW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit TO_EN = ENABLE_EXC != 0 && MEM_TIMEOUT != 0;
  state_t state_q, state_d;
  logic [1:0] cause_q, cause_d, exc_cause;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0] op, funct;
  logic is_r, is_jr, is_lw, is_sw, is_b, is_bne, is_j, is_jal, is_i;
  logic timeout, irq_take, unused_instr;
  assign op = instr[31:26];
  assign funct = instr[5:0];
  assign unused_instr = ^instr[25:6];
  assign is_r = op == 6'b000000;
  assign is_jr = is_r && funct == 6'b001000;
  assign is_lw = op == 6'b100011;
  assign is_sw = op == 6'b101011;
  assign is_b = op[5:1] == 5'b00010;
  assign is_bne = op == 6'b000101;
  assign is_j = op == 6'b000010;
  assign is_jal = op == 6'b000011;
  assign is_i = op[5:3] == 3'b001;
  assign timeout = TO_EN && !mem_ready && cnt_q == CW'(MEM_TIMEOUT - 1);
  // irq is only taken at the very start of a fetch, before any stall
  assign irq_take = ENABLE_EXC != 0 && state_q == FETCH && cnt_q == '0 && irq;
  assign state = rst ? '0 : STATE_W'(state_q);
  assign cause = rst ? 2'd0 : cause_q;
  always_comb begin
    pc_en = 1'b0;
    pc_source = 2'b00;
    ior_d = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    mem_to_reg = 2'b00;
    reg_dst = 2'b00;
    reg_write = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    alu_op = 3'b000;
    epc_write = 1'b0;
    exc_cause = 2'd2;
    state_d = FETCH;
    case (state_q)
      FETCH: begin
        mem_read = !irq_take;
        alu_src_b = 2'b01;
        ir_write = mem_ready && !irq_take;
        pc_en = mem_ready && !irq_take;
        exc_cause = irq_take ? 2'd3 : 2'd2;
        state_d = irq_take || timeout ? EXC : mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        exc_cause = 2'd1;
        state_d = is_jr || is_j || is_jal ? EXEC_J : is_r ? EXEC_R : is_b ? EXEC_B :
                  is_lw || is_sw ? EXEC_M : is_i ? EXEC_I : ENABLE_EXC != 0 ? EXC : FETCH;
      end
      EXEC_M: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d = is_sw ? MEM_S : MEM_L;
      end
      MEM_L: begin
        mem_read = 1'b1;
        ior_d = 1'b1;
        state_d = mem_ready ? WB_L : timeout ? EXC : MEM_L;
      end
      WB_L: begin
        reg_write = 1'b1;
        mem_to_reg = 2'b01;
      end
      MEM_S: begin
        mem_write = 1'b1;
        ior_d = 1'b1;
        state_d = mem_ready ? FETCH : timeout ? EXC : MEM_S;
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op = 3'b010;
        state_d = WB_R;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op = 3'b011;
        state_d = WB_R;
      end
      WB_R: begin
        reg_write = 1'b1;
        reg_dst = is_r ? 2'b01 : 2'b00;
      end
      EXEC_B: begin
        alu_src_a = 1'b1;
        alu_op = 3'b001;
        pc_source = 2'b01;
        pc_en = is_bne ? !zero : zero;
      end
      EXEC_J: begin
        pc_en = 1'b1;
        // jr routes A+0 through the ALU; jal links PC (already PC+4) into $31
        pc_source = is_jr ? 2'b00 : 2'b10;
        alu_src_a = is_jr;
        reg_write = is_jal;
        reg_dst = is_jal ? 2'b10 : 2'b00;
        mem_to_reg = is_jal ? 2'b10 : 2'b00;
      end
      EXC: begin
        epc_write = 1'b1;
        pc_en = 1'b1;
        pc_source = 2'b11;
      end
      default: state_d = FETCH;
    endcase
    // only the wait states can hold, so "no state change" means a stalled cycle
    cnt_d = state_d == state_q ? (&cnt_q ? cnt_q : cnt_q + 1'b1) : '0;
    cause_d = state_d == EXC ? exc_cause : cause_q;
    if (rst) begin
      pc_en = 1'b0;
      pc_source = 2'b00;
      ior_d = 1'b0;
      mem_read = 1'b0;
      mem_write = 1'b0;
      ir_write = 1'b0;
      mem_to_reg = 2'b00;
      reg_dst = 2'b00;
      reg_write = 1'b0;
      alu_src_a = 1'b0;
      alu_src_b = 2'b00;
      alu_op = 3'b000;
      epc_write = 1'b0;
    end
  end
  always_ff @(posedge cclk) begin
    if (rst) begin
      state_q <= FETCH;
      cause_q <= 2'd0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Next-generation multicycle MIPS control unit. Owns its state register, resolving branches internally from the ALU zero flag.
- Supports variable-latency memory through a `mem_ready` stall handshake with a timeout.
- Adds `bne`, `jal` and `jr`.
- Adds a precise exception path covering illegal opcode, bus timeout and external interrupt, with EPC/cause capture.
- Sits between the instruction register/ALU flags and the multicycle datapath muxes and enables.

Parameters:
- `ENABLE_EXC`, default 1. 0 means illegal opcodes execute as a no-op, irq is ignored and the timeout is disabled.
- `MEM_TIMEOUT`, default 15. Number of stalled cycles in a memory state before a bus fault. 0 disables the timeout.
- `STATE_W`, default 4. Width of the exported state; must be at least 4.

Ports:
- `cclk` input 1: clock, rising edge.
- `rst` input 1: synchronous reset, active-high.
- `instr` input 32: IR contents.
- `zero` input 1: ALU zero flag.
- `mem_ready` input 1: memory access complete this cycle.
- `irq` input 1: level interrupt request.
- `pc_en` output 1: PC load enable.
- `pc_source` output 2: 00 ALU result, 01 ALUOut, 10 jump target, 11 exception vector.
- `ior_d` output 1: memory address mux; 1 selects ALUOut.
- `mem_read` output 1: memory read strobe.
- `mem_write` output 1: memory write strobe.
- `ir_write` output 1: IR load enable.
- `mem_to_reg` output 2: write-back source; 00 ALUOut, 01 MDR, 10 PC.
- `reg_dst` output 2: destination register; 00 rt, 01 rd, 10 $31.
- `reg_write` output 1: register file write enable.
- `alu_src_a` output 1: 1 selects A register, 0 selects PC.
- `alu_src_b` output 2: 00 B, 01 const 4, 10 sign-extended imm, 11 shifted sign-extended imm.
- `alu_op` output 3: 000 add, 001 sub, 010 funct, 011 I-type opcode.
- `epc_write` output 1: EPC load enable.
- `cause` output 2: 0 none, 1 illegal, 2 bus timeout, 3 irq.
- `state` output STATE_W: current state.

Behaviour:
- **Opcode decode** (`instr[31:26]`):
  - 000000: R-type; funct 001000 is `jr`.
  - 100011 `lw`, 101011 `sw`, 000100 `beq`, 000101 `bne`, 000010 `j`, 000011 `jal`.
  - 001xxx: I-type ALU.
  - Anything else is illegal.
- **States:** FETCH 0, DECODE 1, EXEC_M 2, MEM_L 3, WB_L 4, MEM_S 5, EXEC_R 6, WB_R 7, EXEC_B 8, EXEC_J 9, EXEC_I 10, EXC 11. Codes 12–15 go to FETCH.
- **Outputs** are combinational from the state register; unlisted outputs are 0.
  - FETCH: `mem_read`=1, `alu_src_b`=01, `ir_write`=`pc_en`=`mem_ready`. Advance to DECODE on `mem_ready`, otherwise hold.
  - DECODE: `alu_src_b`=11. Next state: R→EXEC_R, `jr`/`j`/`jal`→EXEC_J, `beq`/`bne`→EXEC_B, `lw`/`sw`→EXEC_M, I-type→EXEC_I, illegal→EXC (cause 1), or FETCH if `ENABLE_EXC`=0.
  - EXEC_M: `alu_src_a`=1, `alu_src_b`=10. Next is MEM_L for `lw`, MEM_S for `sw`.
  - MEM_L: `mem_read`=1, `ior_d`=1. Hold until `mem_ready`, then go to WB_L.
  - WB_L: `reg_write`=1, `mem_to_reg`=01. Next is FETCH.
  - MEM_S: `mem_write`=1, `ior_d`=1. Hold until `mem_ready`, then go to FETCH. `mem_write` stays high throughout the stall.
  - EXEC_R: `alu_src_a`=1, `alu_op`=010. Next is WB_R.
  - EXEC_I: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=011. Next is WB_R.
  - WB_R: `reg_write`=1; `reg_dst`=01 for R-type, 00 for I-type. Next is FETCH.
  - EXEC_B: `alu_src_a`=1, `alu_op`=001, `pc_source`=01. `pc_en` = `zero` for `beq`, ~`zero` for `bne`. Next is FETCH.
  - EXEC_J: `pc_en`=1. Next is FETCH.
    - `j`/`jal`: `pc_source`=10.
    - `jal` additionally: `reg_write`=1, `reg_dst`=10, `mem_to_reg`=10; PC already holds PC+4.
    - `jr`: `pc_source`=00, `alu_src_a`=1, `alu_src_b`=00; rt=$0 so the ALU computes A+0.
  - EXC: `epc_write`=1, `pc_en`=1, `pc_source`=11. Lasts one cycle, then FETCH.
- **Wait counter:** increments each cycle that FETCH, MEM_L or MEM_S is stalled, and clears on any state change.
  - Bus fault: if the counter equals `MEM_TIMEOUT`−1 and `mem_ready`=0 (with `MEM_TIMEOUT`≠0 and `ENABLE_EXC`=1), the next state is EXC with cause 2.
  - If `mem_ready` arrives in the same cycle, `mem_ready` wins.
- **Interrupts:** irq is sampled only in FETCH with counter=0 and `ENABLE_EXC`=1. If set, the next state is EXC with cause 3, and `mem_read`, `ir_write` and `pc_en` are suppressed that cycle. irq has priority over fetch.
- **Cause register:** `cause` is loaded on entry to EXC and holds until the next exception.
- **Reset:**
  - Next state FETCH; `cause`=0, counter=0.
  - While `rst`=1, `pc_en`, `ir_write`, `reg_write`, `mem_read`, `mem_write` and `epc_write` are forced to 0; all other outputs are 0.
  - Reset mid-stall or mid-instruction abandons the access with no write strobe.

Test Plan:
- `lw` with `mem_ready` tied high → states 0,1,2,3,4,0 in 5 cycles; `reg_write`=1 and `mem_to_reg`=01 in state 4 only.
- `bne` with `zero`=0 → `pc_en`=1 and `pc_source`=01 in state 8; same instruction with `zero`=1 → `pc_en`=0.
- `sw` with `mem_ready` low for 3 cycles → MEM_S held 4 cycles with `mem_write` continuously 1, then FETCH.
- `MEM_TIMEOUT`=15, `mem_ready` held 0 in MEM_L → EXC after 15 stalled cycles, `cause`=2, `epc_write`=1 for 1 cycle, then FETCH.
- Opcode 111111 → DECODE→EXC with `cause`=1. With `ENABLE_EXC`=0 → DECODE→FETCH and `cause` stays 0.
- irq=1 on the first FETCH cycle → EXC with `cause`=3 and no `ir_write`. `rst` pulsed during a MEM_S stall → FETCH next cycle with `mem_write`=0.
